// File: rtl/otter_mem_pkg.sv
// Shared types for the OTTER memory responder: access sizes, FSM states,
// SRAM geometry and small alignment helpers.
package otter_mem_pkg;

  localparam int SRAM_AW = 14;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_D = 2'd1,
    ST_WAIT_I = 2'd2,
    ST_PEND_I = 2'd3
  } mem_state_e;

  // Encoding 3 is served as a word access.
  function automatic mem_size_e to_size(input logic [1:0] sz);
    unique case (sz)
      2'd0:    return SZ_BYTE;
      2'd1:    return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_size_e sz,
                                         input logic [1:0] lo);
    unique case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/otter_mem_align.sv
// Store lane steering and load shift/extension for the OTTER data port.
// Word accesses ignore addr[1:0]; half accesses ignore addr[0].
module otter_mem_align
  import otter_mem_pkg::*;
(
  input  mem_size_e   size,
  input  logic        uns,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] din,
  input  logic [31:0] rdata,
  output logic [3:0]  lane_we,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext
);

  logic [1:0]  off;
  logic [31:0] sh;

  always_comb begin
    off     = 2'b00;
    lane_we = 4'b1111;
    wdata   = din;
    unique case (1'b1)
      size == SZ_BYTE: begin
        off     = addr_lo;
        lane_we = 4'b0001 << addr_lo;
        wdata   = {4{din[7:0]}};
      end
      size == SZ_HALF: begin
        off     = {addr_lo[1], 1'b0};
        lane_we = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{din[15:0]}};
      end
      default: ;
    endcase
  end

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    rdata_ext = sh;
    unique case (1'b1)
      size == SZ_BYTE:
        rdata_ext = {{24{~uns & sh[7]}}, sh[7:0]};
      size == SZ_HALF:
        rdata_ext = {{16{~uns & sh[15]}}, sh[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/otter_mem_responder.sv
// Two-port (fetch + data) responder in front of a single-ported wait-state SRAM.
// Define MEM_MISALIGN_TRAP_EN to block misaligned accesses and pulse MEM_ERR.
module otter_mem_responder
  import otter_mem_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               MEM_RDEN1,
  input  logic [31:0]        MEM_ADDR1,
  output logic [31:0]        MEM_DOUT1,
  input  logic               MEM_RDEN2,
  input  logic               MEM_WE2,
  input  logic [31:0]        MEM_ADDR2,
  input  logic [31:0]        MEM_DIN2,
  input  logic [1:0]         MEM_SIZE,
  input  logic               MEM_UNSIGNED,
  output logic [31:0]        MEM_DOUT2,
  output logic               MEM_BUSY,
  output logic               MEM_ERR,
  output logic               SRAM_EN,
  output logic [3:0]         SRAM_WE,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [31:0]        SRAM_WDATA,
  input  logic [31:0]        SRAM_RDATA,
  input  logic               SRAM_READY
);

  mem_state_e  state;
  logic        pend;
  logic [15:0] lat_daddr;
  logic [15:0] lat_iaddr;
  logic        lat_we;
  logic        lat_uns;
  mem_size_e   lat_size;
  logic [31:0] lat_din;
  logic [31:0] dout1;
  logic [31:0] dout2;
  logic        err;

  logic        data_req;
  logic        srv_data;
  logic        srv_fetch;
  logic        srv_we;
  logic        srv_uns;
  logic [15:0] srv_addr;
  mem_size_e   srv_size;
  logic [31:0] srv_din;
  logic        trap;
  logic        fetch_mis;
  logic        err_n;
  logic        pend_set;
  logic        en;
  logic [3:0]  lane_we;
  logic [31:0] wdata;
  logic [31:0] rdata_ext;
  logic        unused_hi;

  assign unused_hi = ^{MEM_ADDR1[31:16], MEM_ADDR2[31:16]};
  assign data_req  = MEM_RDEN2 | MEM_WE2;

  // Pick the request on the SRAM this cycle: live inputs in IDLE, latched otherwise.
  always_comb begin
    srv_data  = 1'b0;
    srv_fetch = 1'b0;
    srv_we    = 1'b0;
    srv_uns   = 1'b0;
    srv_addr  = lat_iaddr;
    srv_size  = SZ_WORD;
    srv_din   = '0;
    unique case (state)
      ST_IDLE: begin
        if (data_req) begin
          srv_data = 1'b1;
          srv_we   = MEM_WE2;
          srv_uns  = MEM_UNSIGNED;
          srv_addr = MEM_ADDR2[15:0];
          srv_size = to_size(MEM_SIZE);
          srv_din  = MEM_DIN2;
        end else if (MEM_RDEN1) begin
          srv_fetch = 1'b1;
          srv_addr  = MEM_ADDR1[15:0];
        end
      end
      ST_WAIT_D: begin
        srv_data = 1'b1;
        srv_we   = lat_we;
        srv_uns  = lat_uns;
        srv_addr = lat_daddr;
        srv_size = lat_size;
        srv_din  = lat_din;
      end
      ST_WAIT_I, ST_PEND_I: begin
        srv_fetch = 1'b1;
      end
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign fetch_mis = MEM_ADDR1[1:0] != 2'b00;
  assign trap = (state == ST_IDLE) &
                (srv_data ? is_misaligned(srv_size, srv_addr[1:0])
                          : srv_fetch & fetch_mis);
  assign err_n = trap |
                 ((state == ST_IDLE) & data_req & MEM_RDEN1 & fetch_mis);
`else
  assign fetch_mis = 1'b0;
  assign trap      = 1'b0;
  assign err_n     = 1'b0;
`endif

  assign pend_set = (state == ST_IDLE) & srv_data & MEM_RDEN1 & ~fetch_mis;
  assign en       = RESET_N & (srv_data | srv_fetch) & ~trap;

  otter_mem_align u_align (
    .size      (srv_size),
    .uns       (srv_uns),
    .addr_lo   (srv_addr[1:0]),
    .din       (srv_din),
    .rdata     (SRAM_RDATA),
    .lane_we   (lane_we),
    .wdata     (wdata),
    .rdata_ext (rdata_ext)
  );

  assign SRAM_EN    = en;
  assign SRAM_WE    = (en & srv_we) ? lane_we : 4'b0000;
  assign SRAM_ADDR  = srv_addr[15:2];
  assign SRAM_WDATA = wdata;
  assign MEM_DOUT1  = dout1;
  assign MEM_DOUT2  = dout2;
  assign MEM_ERR    = err;
  assign MEM_BUSY   = state != ST_IDLE;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      pend      <= 1'b0;
      lat_daddr <= '0;
      lat_iaddr <= '0;
      lat_we    <= 1'b0;
      lat_uns   <= 1'b0;
      lat_size  <= SZ_WORD;
      lat_din   <= '0;
      dout1     <= '0;
      dout2     <= '0;
      err       <= 1'b0;
    end else begin
      err <= err_n;
      unique case (state)
        ST_IDLE: begin
          if (en && srv_data) begin
            lat_daddr <= srv_addr;
            lat_we    <= srv_we;
            lat_uns   <= srv_uns;
            lat_size  <= srv_size;
            lat_din   <= srv_din;
            lat_iaddr <= MEM_ADDR1[15:0];
            if (SRAM_READY) begin
              if (!srv_we) dout2 <= rdata_ext;
              state <= pend_set ? ST_PEND_I : ST_IDLE;
            end else begin
              pend  <= pend_set;
              state <= ST_WAIT_D;
            end
          end else if (en) begin
            lat_iaddr <= srv_addr;
            if (SRAM_READY) dout1 <= SRAM_RDATA;
            else            state <= ST_WAIT_I;
          end
        end
        ST_WAIT_D: begin
          if (SRAM_READY) begin
            if (!srv_we) dout2 <= rdata_ext;
            pend  <= 1'b0;
            state <= pend ? ST_PEND_I : ST_IDLE;
          end
        end
        ST_WAIT_I, ST_PEND_I: begin
          if (SRAM_READY) begin
            dout1 <= SRAM_RDATA;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
